// File: rtl/z16_board_pkg.sv
// Shared definitions for the Z16 board run/step controller.
//   mode_e     : controller mode encodings, also driven out on o_mode
//   DEF_*      : default timing constants for the 27 MHz board
//   cnt_width  : bits needed to hold a counter value up to max_val
package z16_board_pkg;

    typedef enum logic [1:0] {
        MODE_RST_HOLD = 2'b00,
        MODE_HALT     = 2'b01,
        MODE_RUN      = 2'b10,
        MODE_STEP     = 2'b11
    } mode_e;

    localparam int unsigned DEF_DIV_COUNT       = 2700000;   // 10 Hz run rate
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 270000;    // 10 ms
    localparam int unsigned DEF_LONG_CYCLES     = 27000000;  // 1 s
    localparam int unsigned DEF_RST_HOLD_CYCLES = 16;
    localparam bit          DEF_BOOT_RUN        = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/z16_button_debounce.sv
// Button front end: two-flop synchroniser, debouncer and press-length timer.
//   i_clk       : board clock
//   i_rst       : synchronous active-high reset
//   i_button    : raw active-low button, asynchronous to i_clk
//   o_short_evt : one-cycle pulse, cycle after a debounced release of a short press
//   o_long_evt  : one-cycle pulse when a held press reaches LONG_CYCLES
module z16_button_debounce
    import z16_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    output logic o_short_evt,
    output logic o_long_evt
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int unsigned PR_W = cnt_width(LONG_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(LONG_CYCLES - 1);
    localparam logic [PR_W-1:0] PR_MAX  = PR_W'(LONG_CYCLES);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_db;
    logic            r_db_prev;
    logic [DB_W-1:0] r_stab_cnt;
    logic [PR_W-1:0] r_press_cnt;
    logic            r_long_done;
    logic            r_short_evt;
    logic            r_long_evt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_db        <= 1'b1;
            r_db_prev   <= 1'b1;
            r_stab_cnt  <= '0;
            r_press_cnt <= '0;
            r_long_done <= 1'b0;
            r_short_evt <= 1'b0;
            r_long_evt  <= 1'b0;
        end else begin
            r_sync1   <= i_button;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;

            // Rising edge of db, seen one cycle late; a press already classified long stays silent.
            r_short_evt <= r_db & ~r_db_prev & ~r_long_done;
            r_long_evt  <= 1'b0;

            if (r_sync2 != r_db) begin
                if (r_stab_cnt == DB_LAST) begin
                    r_stab_cnt <= '0;
                    r_db       <= r_sync2;
                end else begin
                    r_stab_cnt <= r_stab_cnt + 1'b1;
                end
            end else begin
                r_stab_cnt <= '0;
            end

            // Timer is idle while released, so it starts from zero at every debounced press.
            // r_long_done is read by the short-event logic in the cycle after release, before
            // this branch clears it.
            if (r_db) begin
                r_press_cnt <= '0;
                r_long_done <= 1'b0;
            end else if (r_press_cnt != PR_MAX) begin
                r_press_cnt <= r_press_cnt + 1'b1;
                if (r_press_cnt == PR_LAST) begin
                    r_long_evt  <= 1'b1;
                    r_long_done <= 1'b1;
                end
            end
        end
    end

    assign o_short_evt = r_short_evt;
    assign o_long_evt  = r_long_evt;

endmodule

// File: rtl/z16_run_controller.sv
// Run/step controller for the Z16 CPU: gates CPU progress with a one-cycle clock enable.
//   i_clk      : 27 MHz board clock
//   i_rst      : synchronous active-high reset
//   i_button   : raw active-low run/step button
//   i_halt_req : one-cycle pulse from the CPU when HLT retires
//   o_cpu_ce   : one-cycle CPU clock enable (registered)
//   o_cpu_rst  : CPU synchronous reset, high only in RST_HOLD (registered)
//   o_mode     : 00 RST_HOLD, 01 HALT, 10 RUN, 11 STEP (registered)
//   o_ce_count : number of ce pulses issued, 16-bit wrapping
module z16_run_controller
    import z16_board_pkg::*;
#(
    parameter int unsigned DIV_COUNT       = DEF_DIV_COUNT,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter bit          BOOT_RUN        = DEF_BOOT_RUN
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_button,
    input  logic        i_halt_req,
    output logic        o_cpu_ce,
    output logic        o_cpu_rst,
    output logic [1:0]  o_mode,
    output logic [15:0] o_ce_count
);

    localparam int unsigned TICK_W = cnt_width(DIV_COUNT - 1);
    localparam int unsigned HOLD_W = cnt_width(RST_HOLD_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    mode_e             r_state;
    logic [TICK_W-1:0] r_tick;
    logic [HOLD_W-1:0] r_hold;
    logic              r_ce;
    logic              r_cpu_rst;
    logic [15:0]       r_ce_count;

    logic              w_short_evt;
    logic              w_long_evt;
    logic [TICK_W-1:0] w_tick_next;

    z16_button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
    ) u_button (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_button    (i_button),
        .o_short_evt (w_short_evt),
        .o_long_evt  (w_long_evt)
    );

    assign w_tick_next = (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;

    // ce is registered alongside the tick counter, so it is high exactly while r_tick holds
    // DIV_COUNT-1. An event sampled on the edge that would raise it moves to HALT instead,
    // which is what suppresses the coinciding tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= MODE_RST_HOLD;
            r_hold     <= '0;
            r_tick     <= '0;
            r_ce       <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_ce_count <= '0;
        end else begin
            r_ce_count <= r_ce_count + {15'd0, r_ce};
            unique case (r_state)
                MODE_RST_HOLD: begin
                    r_ce <= 1'b0;
                    if (r_hold == HOLD_LAST) begin
                        r_cpu_rst <= 1'b0;
                        r_tick    <= '0;
                        r_state   <= BOOT_RUN ? MODE_RUN : MODE_HALT;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                MODE_RUN: begin
                    if (w_long_evt || i_halt_req) begin
                        r_state <= MODE_HALT;
                        r_ce    <= 1'b0;
                    end else begin
                        r_tick <= w_tick_next;
                        r_ce   <= (w_tick_next == TICK_LAST);
                    end
                end
                MODE_HALT: begin
                    if (w_short_evt) begin
                        r_state <= MODE_STEP;
                        r_ce    <= 1'b1;
                    end else if (w_long_evt) begin
                        r_state <= MODE_RUN;
                        r_tick  <= '0;
                        r_ce    <= 1'b0;
                    end else begin
                        r_ce <= 1'b0;
                    end
                end
                MODE_STEP: begin
                    r_state <= MODE_HALT;
                    r_ce    <= 1'b0;
                end
            endcase
        end
    end

    assign o_cpu_ce   = r_ce;
    assign o_cpu_rst  = r_cpu_rst;
    assign o_mode     = r_state;
    assign o_ce_count = r_ce_count;

endmodule

// File: tb/tb_z16_run_controller.sv
// Bench for z16_run_controller with small timing parameters.
module tb_z16_run_controller;

    localparam int unsigned DIV  = 4;
    localparam int unsigned DEB  = 3;
    localparam int unsigned LONG = 10;
    localparam int unsigned HOLD = 2;
    localparam bit          BOOT = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b1;
    logic        halt = 1'b0;
    logic        ce;
    logic        cpu_rst;
    logic [1:0]  mode;
    logic [15:0] cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    z16_run_controller #(
        .DIV_COUNT       (DIV),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .RST_HOLD_CYCLES (HOLD),
        .BOOT_RUN        (BOOT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_button   (btn),
        .i_halt_req (halt),
        .o_cpu_ce   (ce),
        .o_cpu_rst  (cpu_rst),
        .o_mode     (mode),
        .o_ce_count (cnt)
    );

    // Reference model: values are what the outputs should show after the latest edge.
    bit m_valid = 1'b0;
    int m_s1, m_s2, m_db, m_stab, m_low, m_pend, m_short, m_long;
    int m_mode, m_hold, m_age, m_ce, m_cnt;

    task automatic model_edge(input bit r, input bit b, input bit h);
        int db_new;
        int ev_short;
        int ev_long;
        if (r) begin
            m_valid = 1'b1;
            m_s1 = 1; m_s2 = 1; m_db = 1; m_stab = 0; m_low = 0;
            m_pend = 0; m_short = 0; m_long = 0;
            m_mode = 0; m_hold = 0; m_age = 0; m_ce = 0; m_cnt = 0;
            return;
        end
        if (!m_valid) return;
        ev_short = m_short;
        ev_long  = m_long;
        // button: count low cycles of the debounced level
        m_long = 0;
        if (m_db == 0) begin
            m_low++;
            if (m_low == int'(LONG)) m_long = 1;
        end
        m_short = m_pend;
        m_pend  = 0;
        db_new  = m_db;
        if (m_s2 != m_db) begin
            m_stab++;
            if (m_stab == int'(DEB)) begin
                db_new = m_s2;
                m_stab = 0;
            end
        end else begin
            m_stab = 0;
        end
        if (m_db == 0 && db_new == 1) m_pend = (m_low < int'(LONG)) ? 1 : 0;
        if (m_db == 1 && db_new == 0) m_low = 0;
        m_db = db_new;
        m_s2 = m_s1;
        m_s1 = b;
        // controller: m_age is the 1-based cycle number within the current RUN stretch
        m_cnt = (m_cnt + m_ce) % 65536;
        case (m_mode)
            0: begin
                m_ce = 0;
                m_hold++;
                if (m_hold == int'(HOLD)) begin
                    m_mode = BOOT ? 2 : 1;
                    m_age  = 1;
                end
            end
            2: begin
                if (ev_long != 0 || h) begin
                    m_mode = 1;
                    m_ce   = 0;
                end else begin
                    m_age++;
                    m_ce = (m_age % int'(DIV) == 0) ? 1 : 0;
                end
            end
            1: begin
                if (ev_short != 0) begin
                    m_mode = 3;
                    m_ce   = 1;
                end else if (ev_long != 0) begin
                    m_mode = 2;
                    m_age  = 1;
                    m_ce   = 0;
                end else begin
                    m_ce = 0;
                end
            end
            default: begin
                m_mode = 1;
                m_ce   = 0;
            end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit b, input bit h);
        rst  = r;
        btn  = b;
        halt = h;
        @(posedge clk);
        model_edge(r, b, h);
        @(negedge clk);
        if (m_valid) begin
            check("model_mode", 32'(mode), 32'(m_mode));
            check("model_ce", 32'(ce), 32'(m_ce));
            check("model_cpu_rst", 32'(cpu_rst), (m_mode == 0) ? 32'd1 : 32'd0);
            check("model_ce_count", 32'(cnt), 32'(m_cnt));
        end
    endtask

    // Steps with fixed inputs until o_mode equals target; returns the step count or -1.
    task automatic wait_mode(input string name, input logic [1:0] target, input bit b,
                             input int max_steps, output int steps);
        steps = -1;
        for (int i = 1; i <= max_steps; i++) begin
            step(1'b0, b, 1'b0);
            if (mode == target) begin
                steps = i;
                break;
            end
        end
        if (steps < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: mode %0d never reached within %0d cycles", name, target, max_steps);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          btn;
        bit          halt;
        logic [1:0]  mode;
        bit          ce;
        bit          cpu_rst;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int  n;
        bit  seen_step;
        bit  lvl;
        int  left;

        // reset, hold, RUN cadence, plus a 2-cycle button glitch that must be ignored
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 16'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 16'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 16'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 16'd1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 16'd2};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 16'd2};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].btn, tbl[i].halt);
            check($sformatf("tbl%0d_mode", i), 32'(mode), 32'(tbl[i].mode));
            check($sformatf("tbl%0d_ce", i), 32'(ce), 32'(tbl[i].ce));
            check($sformatf("tbl%0d_cpu_rst", i), 32'(cpu_rst), 32'(tbl[i].cpu_rst));
            check($sformatf("tbl%0d_count", i), 32'(cnt), 32'(tbl[i].cnt));
        end

        // long press in RUN: HALT, release gives no STEP, count frozen at 6
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
        check("long_to_halt", 32'(mode), 32'd1);
        seen_step = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (mode == 2'b11) seen_step = 1'b1;
        end
        check("long_release_no_step", 32'(seen_step), 32'd0);
        check("halt_count_frozen", 32'(cnt), 32'd6);
        check("halt_mode", 32'(mode), 32'd1);

        // short press in HALT: STEP appears 2+DEB+2 cycles after the raw release
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
        wait_mode("short_step", 2'b11, 1'b1, 30, n);
        check("step_latency", 32'(n), 32'(2 + DEB + 2));
        check("step_ce", 32'(ce), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        check("step_back_halt", 32'(mode), 32'd1);
        check("step_ce_clear", 32'(ce), 32'd0);
        check("step_count", 32'(cnt), 32'd7);

        // long press to RUN, then halt request on the edge that would raise the 4th-cycle tick
        wait_mode("long_to_run", 2'b10, 1'b0, 40, n);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("pre_tick_ce", 32'(ce), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        check("halt_req_mode", 32'(mode), 32'd1);
        check("halt_req_ce", 32'(ce), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);

        // long press again: first ce in the 4th RUN cycle
        wait_mode("long_to_run2", 2'b10, 1'b0, 40, n);
        step(1'b0, 1'b0, 1'b0);
        check("run2_c2_ce", 32'(ce), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("run2_c3_ce", 32'(ce), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("run2_c4_ce", 32'(ce), 32'd1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);

        // reach STEP with the button held again, then reset
        step(1'b0, 1'b1, 1'b1);
        check("halt_again", 32'(mode), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        wait_mode("held_step", 2'b11, 1'b0, 10, n);
        step(1'b1, 1'b0, 1'b0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        check("held_release_ignored", 32'(mode), 32'd2);

        // random presses, halt requests and occasional resets against the model
        lvl  = 1'b1;
        left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = $urandom_range(1, 24);
            end
            left--;
            step(($urandom_range(0, 399) == 0), lvl, ($urandom_range(0, 29) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
